// File: rtl/ls_cnt_mc_if.sv
// ls_cnt_mc_if: bundles the per-channel lanes, shared controls and readout
// outputs of the multi-channel bit-error counter. Clock and reset stay
// plain ports on the counter itself.
// There is no handshake: inputs are sampled every rising clock edge and
// outputs are live registered values that the readout bank may read at any time.
// STATE_DBG exposes each channel FSM (2 bits per channel: 0 HUNT, 1 ARM, 2 LOCK).
interface ls_cnt_mc_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 32
);
    logic                    CLR;
    logic [N_CH-1:0]         CREST_IN;
    logic                    RPG_IN;
    logic [1:0]              DLY_SEL;
    logic [N_CH*CNT_W-1:0]   ERR_CNT;
    logic [N_CH-1:0]         COMP_OUT;
    logic [N_CH-1:0]         LOCKED;
    logic [N_CH-1:0]         SAT;
    logic [N_CH-1:0]         LOL;
    logic [2*N_CH-1:0]       STATE_DBG;

    // Pad-capture / control side drives the lanes and controls.
    modport master (
        output CLR, CREST_IN, RPG_IN, DLY_SEL,
        input  ERR_CNT, COMP_OUT, LOCKED, SAT, LOL, STATE_DBG
    );

    // Counter side consumes lanes and controls, drives the readout.
    modport slave (
        input  CLR, CREST_IN, RPG_IN, DLY_SEL,
        output ERR_CNT, COMP_OUT, LOCKED, SAT, LOL, STATE_DBG
    );
endinterface

// File: rtl/ls_cnt_mc.sv
// ls_cnt_mc: per-channel bit-error counter. Each lane passes through a
// 4-flop sample chain with selectable tap, hunts for a rising edge, arms for
// a bounded window waiting for RPG_IN=1, then locks and counts mismatches
// into a saturating counter. A run of LOSS_TH consecutive mismatches drops
// lock and sets a sticky loss-of-lock flag.
module ls_cnt_mc #(
    parameter int N_CH    = 8,
    parameter int CNT_W   = 32,
    parameter int ARM_WIN = 4,
    parameter int LOSS_TH = 16
) (
    input  logic      CLK,
    input  logic      RST_PER_N,
    ls_cnt_mc_if.slave bus
);

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    localparam int WIN_W = $clog2(ARM_WIN + 1);
    localparam int RUN_W = (LOSS_TH > 0) ? $clog2(LOSS_TH + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(ARM_WIN);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    // Run value at which the next mismatch is the LOSS_TH-th in a row.
    localparam logic [RUN_W-1:0] RUN_LAST = (LOSS_TH > 0) ? RUN_W'(LOSS_TH - 1) : '0;

    logic [N_CH-1:0][3:0]       sh_q,   sh_d;
    logic [N_CH-1:0]            sd_q,   sd_d;
    logic [N_CH-1:0][1:0]       st_q,   st_d;
    logic [N_CH-1:0][WIN_W-1:0] win_q,  win_d;
    logic [N_CH-1:0][RUN_W-1:0] run_q,  run_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
    logic [N_CH-1:0]            comp_q, comp_d;
    logic [N_CH-1:0]            sat_q,  sat_d;
    logic [N_CH-1:0]            lol_q,  lol_d;

    logic [N_CH-1:0]            s_w;
    logic [N_CH-1:0]            m_w;
    logic [N_CH-1:0]            locked_w;

    // Pick the delayed sample per channel and form the mismatch against the reference.
    always_comb begin
        s_w = '0;
        m_w = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            s_w[ch] = sh_q[ch][bus.DLY_SEL];
            m_w[ch] = s_w[ch] ^ bus.RPG_IN;
        end
    end

    // Next-state for sample chains, channel FSMs, run/window counters and error counters.
    always_comb begin
        sh_d   = sh_q;
        sd_d   = sd_q;
        st_d   = st_q;
        win_d  = win_q;
        run_d  = run_q;
        cnt_d  = cnt_q;
        comp_d = '0;
        sat_d  = sat_q;
        lol_d  = lol_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            // Sample chain and edge-detect history are never cleared by CLR,
            // so re-arming after a clear needs a fresh rising edge.
            sh_d[ch] = {sh_q[ch][2:0], bus.CREST_IN[ch]};
            sd_d[ch] = s_w[ch];

            // Count the registered mismatch flag; hold at all-ones.
            if (comp_q[ch] && (cnt_q[ch] != CNT_ONES)) begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                if (cnt_q[ch] == (CNT_ONES - CNT_ONE)) begin
                    sat_d[ch] = 1'b1;
                end
            end

            case (st_q[ch])
                S_HUNT: begin
                    if (s_w[ch] && !sd_q[ch]) begin
                        st_d[ch]  = S_ARM;
                        win_d[ch] = WIN_LOAD;
                    end
                end
                S_ARM: begin
                    if (bus.RPG_IN) begin
                        st_d[ch] = S_LOCK;
                    end else if (win_q[ch] == WIN_ONE) begin
                        st_d[ch] = S_HUNT;
                    end else begin
                        win_d[ch] = win_q[ch] - WIN_ONE;
                    end
                end
                S_LOCK: begin
                    comp_d[ch] = m_w[ch];
                    if (LOSS_TH > 0) begin
                        if (m_w[ch]) begin
                            if (run_q[ch] == RUN_LAST) begin
                                st_d[ch]  = S_HUNT;
                                lol_d[ch] = 1'b1;
                                run_d[ch] = '0;
                            end else begin
                                run_d[ch] = run_q[ch] + RUN_ONE;
                            end
                        end else begin
                            run_d[ch] = '0;
                        end
                    end
                end
                default: st_d[ch] = S_HUNT;
            endcase

            // Synchronous clear overrides everything except the sample path.
            if (bus.CLR) begin
                st_d[ch]   = S_HUNT;
                win_d[ch]  = '0;
                run_d[ch]  = '0;
                cnt_d[ch]  = '0;
                comp_d[ch] = 1'b0;
                sat_d[ch]  = 1'b0;
                lol_d[ch]  = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_PER_N) begin
        if (!RST_PER_N) begin
            sh_q   <= '0;
            sd_q   <= '0;
            st_q   <= '0;
            win_q  <= '0;
            run_q  <= '0;
            cnt_q  <= '0;
            comp_q <= '0;
            sat_q  <= '0;
            lol_q  <= '0;
        end else begin
            sh_q   <= sh_d;
            sd_q   <= sd_d;
            st_q   <= st_d;
            win_q  <= win_d;
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            comp_q <= comp_d;
            sat_q  <= sat_d;
            lol_q  <= lol_d;
        end
    end

    // LOCKED is a straight decode of the registered FSM state.
    always_comb begin
        locked_w = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            locked_w[ch] = (st_q[ch] == S_LOCK);
        end
    end

    assign bus.ERR_CNT   = cnt_q;
    assign bus.COMP_OUT  = comp_q;
    assign bus.LOCKED    = locked_w;
    assign bus.SAT       = sat_q;
    assign bus.LOL       = lol_q;
    assign bus.STATE_DBG = st_q;

endmodule
